// File: rtl/fb_pkg.sv
// Framebuffer geometry and shared types for the clk_pix write/read paths.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: WIDTH/HEIGHT, TOT_PIX, ADDR_W, PIX_W, pix_t, fb_addr_t, arb_state_t.
package fb_pkg;

  localparam int WIDTH   = 640;
  localparam int HEIGHT  = 480;
  localparam int TOT_PIX = WIDTH * HEIGHT;
  localparam int ADDR_W  = $clog2(TOT_PIX);
  localparam int PIX_W   = 24;

  // Pixel layout is {R[23:16], G[15:8], B[7:0]}.
  typedef logic [PIX_W-1:0]  pix_t;
  typedef logic [ADDR_W-1:0] fb_addr_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of req scanning ptr+1, ptr+2, ... modulo N.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is used.
// Ports: req (request vector), ptr (last winner), win (winner index), any (some req set).
module rr_pick
  import fb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] win,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Offset 1 is scanned first so the previous winner ends up last in line.
  always_comb begin
    win  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any = 1'b1;
        win = cand;
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Shares the framebuffer write port between NUM_REQ burst writers, round-robin per burst.
// Latency: valid in IDLE -> ready next cycle; accepted beat -> fb_we/fb_addr/fb_data next cycle.
// Backpressure: ready is one-hot on the granted requester only; others wait for a later grant.
// Ports: clk_pix, rst (async active-low), req_valid/req_last/req_addr/req_data -> req_ready,
//        fb_we/fb_addr/fb_data (registered write), busy, err_oob (sticky) with err_clr.
module fb_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int PIX_W     = fb_pkg::PIX_W,
  parameter int TOT_PIX   = fb_pkg::TOT_PIX,
  parameter int ADDR_W    = $clog2(TOT_PIX),
  parameter int MAX_BURST = 64,
  parameter int STALL_MAX = 16
) (
  input  logic                      clk_pix,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*PIX_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      fb_we,
  output logic [ADDR_W-1:0]         fb_addr,
  output logic [PIX_W-1:0]          fb_data,
  output logic                      busy,
  output logic                      err_oob,
  input  logic                      err_clr
);

  import fb_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int BC_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int SC_W  = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;

  localparam logic [ADDR_W-1:0] ADDR_LIM = ADDR_W'(TOT_PIX);
  localparam logic [BC_W-1:0]   BC_TERM  = BC_W'(MAX_BURST - 1);
  localparam logic [SC_W-1:0]   SC_TERM  = SC_W'(STALL_MAX - 1);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] g, g_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [BC_W-1:0]  bcnt, bcnt_nxt;
  logic [SC_W-1:0]  scnt, scnt_nxt;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  logic              g_valid;
  logic              g_last;
  logic [ADDR_W-1:0] g_addr;
  logic [PIX_W-1:0]  g_data;

  logic beat_acc;
  logic in_bounds;
  logic rel_grant;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .win (pick_idx),
    .any (pick_any)
  );

  // Steer the granted requester's beat onto the internal bus.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_addr  = '0;
    g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g == IDX_W'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_addr  = req_addr[i*ADDR_W +: ADDR_W];
        g_data  = req_data[i*PIX_W +: PIX_W];
      end
    end
  end

  // Ready depends on registered state only, so no valid->ready combinational path exists.
  always_comb begin
    req_ready = '0;
    if (state == ARB_GRANT) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        req_ready[i] = (g == IDX_W'(i));
      end
    end
  end

  assign busy      = (state == ARB_GRANT);
  assign beat_acc  = busy && g_valid;
  assign in_bounds = (g_addr < ADDR_LIM);

  // Release on the burst's last beat, at the burst cap, or after a long stall.
  // Forced releases leave the requester's pending beat untouched; it resumes
  // on its next grant.
  assign rel_grant = busy &&
                     ((beat_acc && (g_last || (bcnt == BC_TERM))) ||
                      (!g_valid && (scnt == SC_TERM)));

  always_comb begin
    state_nxt = state;
    g_nxt     = g;
    ptr_nxt   = ptr;
    bcnt_nxt  = bcnt;
    scnt_nxt  = scnt;
    case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          state_nxt = ARB_GRANT;
          g_nxt     = pick_idx;
          bcnt_nxt  = '0;
          scnt_nxt  = '0;
        end
      end
      ARB_GRANT: begin
        if (beat_acc) begin
          bcnt_nxt = bcnt + BC_W'(1);
          scnt_nxt = '0;
        end else begin
          scnt_nxt = scnt + SC_W'(1);
        end
        // Counters are cleared on release so they never wrap past terminal count.
        if (rel_grant) begin
          state_nxt = ARB_IDLE;
          ptr_nxt   = g;
          bcnt_nxt  = '0;
          scnt_nxt  = '0;
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
      end
    endcase
  end

  // Reset parks ptr on the last requester so requester 0 wins the first arbitration.
  always_ff @(posedge clk_pix or negedge rst) begin
    if (!rst) begin
      state <= ARB_IDLE;
      g     <= '0;
      ptr   <= IDX_W'(NUM_REQ - 1);
      bcnt  <= '0;
      scnt  <= '0;
    end else begin
      state <= state_nxt;
      g     <= g_nxt;
      ptr   <= ptr_nxt;
      bcnt  <= bcnt_nxt;
      scnt  <= scnt_nxt;
    end
  end

  // Write port. An asserted reset clears fb_we at once, killing any write in flight.
  always_ff @(posedge clk_pix or negedge rst) begin
    if (!rst) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      fb_we <= beat_acc && in_bounds;
      if (beat_acc && in_bounds) begin
        fb_addr <= g_addr;
        fb_data <= g_data;
      end
    end
  end

  // Sticky out-of-bounds flag; a new offending beat beats a simultaneous clear.
  always_ff @(posedge clk_pix or negedge rst) begin
    if (!rst) begin
      err_oob <= 1'b0;
    end else if (beat_acc && !in_bounds) begin
      err_oob <= 1'b1;
    end else if (err_clr) begin
      err_oob <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
module tb_fb_write_arbiter;

  localparam int NR  = 4;
  localparam int AW  = 19;
  localparam int PW  = 24;
  localparam int TOT = 307200;

  typedef struct {
    bit            idle;
    bit            last;
    int            addr;
    logic [PW-1:0] data;
    int            tag;
  } beat_t;

  typedef struct {
    int req;
    int cyc;
    int tag;
  } acc_t;

  typedef struct {
    int            addr;
    logic [PW-1:0] data;
    int            cyc;
  } wr_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_last;
  logic [NR*AW-1:0] req_addr;
  logic [NR*PW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             fb_we;
  logic [AW-1:0]    fb_addr;
  logic [PW-1:0]    fb_data;
  logic             busy;
  logic             err_oob;
  logic             err_clr;

  beat_t dq [NR][$];
  acc_t  acc_log[$];
  acc_t  exp_log[$];
  wr_t   exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  fb_write_arbiter #(
    .NUM_REQ   (NR),
    .PIX_W     (PW),
    .TOT_PIX   (TOT),
    .ADDR_W    (AW),
    .MAX_BURST (64),
    .STALL_MAX (16)
  ) dut (
    .clk_pix   (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .fb_we     (fb_we),
    .fb_addr   (fb_addr),
    .fb_data   (fb_data),
    .busy      (busy),
    .err_oob   (err_oob),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add_burst(input int r, input int n, input int a0, input logic [PW-1:0] d0,
                           input bit fin, input int t0);
    for (int k = 0; k < n; k++) begin
      beat_t b;
      b.idle = 1'b0;
      b.last = fin && (k == n - 1);
      b.addr = a0 + k;
      b.data = d0 + PW'(k);
      b.tag  = t0 + k;
      dq[r].push_back(b);
    end
  endtask

  task automatic add_idle(input int r, input int n);
    for (int k = 0; k < n; k++) begin
      beat_t b;
      b.idle = 1'b1;
      b.last = 1'b0;
      b.addr = 0;
      b.data = '0;
      b.tag  = -1;
      dq[r].push_back(b);
    end
  endtask

  task automatic ex(input int r, input int c, input int t);
    acc_t a;
    a.req = r;
    a.cyc = c;
    a.tag = t;
    exp_log.push_back(a);
  endtask

  task automatic chk_log(input string name);
    chk({name, "_count"}, 64'(acc_log.size()), 64'(exp_log.size()));
    for (int i = 0; i < exp_log.size(); i++) begin
      n_cmp++;
      if (i >= acc_log.size()) begin
        n_err++;
        $display("FAIL %s[%0d]: no acceptance, expected req%0d tag%0d cyc%0d",
                 name, i, exp_log[i].req, exp_log[i].tag, exp_log[i].cyc);
      end else if (acc_log[i].req != exp_log[i].req || acc_log[i].cyc != exp_log[i].cyc ||
                   acc_log[i].tag != exp_log[i].tag) begin
        n_err++;
        $display("FAIL %s[%0d]: got req%0d tag%0d cyc%0d, expected req%0d tag%0d cyc%0d",
                 name, i, acc_log[i].req, acc_log[i].tag, acc_log[i].cyc,
                 exp_log[i].req, exp_log[i].tag, exp_log[i].cyc);
      end
    end
    acc_log.delete();
    exp_log.delete();
  endtask

  function automatic bit drv_empty();
    for (int i = 0; i < NR; i++) if (dq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      #1;
      done = drv_empty() && (exp_q.size() == 0) && (busy === 1'b0);
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL %s_timeout: busy=%b pending_writes=%0d, expected idle", name, busy, exp_q.size());
    end
  endtask

  // Driver: presents the head of each requester's queue at the falling edge and
  // records which beats the DUT will take at the next rising edge.
  initial begin
    beat_t b;
    acc_t  a;
    wr_t   w;
    req_valid = '0;
    req_last  = '0;
    req_addr  = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (dq[i].size() == 0) begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end else if (dq[i][0].idle) begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
          void'(dq[i].pop_front());
        end else begin
          req_valid[i]          = 1'b1;
          req_last[i]           = dq[i][0].last;
          req_addr[i*AW +: AW]  = AW'(dq[i][0].addr);
          req_data[i*PW +: PW]  = dq[i][0].data;
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i] === 1'b1) begin
          b     = dq[i].pop_front();
          a.req = i;
          a.cyc = cyc;
          a.tag = b.tag;
          acc_log.push_back(a);
          if (b.addr < TOT) begin
            w.addr = b.addr;
            w.data = b.data;
            w.cyc  = cyc + 1;
            exp_q.push_back(w);
          end
        end
      end
    end
  end

  // Monitor: every framebuffer write must match the oldest expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (fb_we === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL write_unexpected: got addr=%0d data=%06h cyc=%0d, expected no write",
                   fb_addr, fb_data, cyc);
        end else begin
          e = exp_q.pop_front();
          if (fb_addr !== AW'(e.addr) || fb_data !== e.data || cyc != e.cyc) begin
            n_err++;
            $display("FAIL write: got addr=%0d data=%06h cyc=%0d, expected addr=%0d data=%06h cyc=%0d",
                     fb_addr, fb_data, cyc, e.addr, e.data, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int r;
    int ord[5];
    rst     = 1'b0;
    err_clr = 1'b0;

    // Reset defaults, then requester 0 beats requester 2.
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_fb_we", fb_we, 0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_fb_data", fb_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_oob", err_oob, 0);
    chk("rst_req_ready", req_ready, 0);
    @(posedge clk); #1;
    s = cyc;
    add_burst(0, 1, 10, 24'h000A00, 1'b1, 0);
    add_burst(2, 1, 20, 24'h000B00, 1'b1, 0);
    ex(0, s + 1, 0);
    ex(2, s + 3, 0);
    wait_idle("first");
    chk_log("first_grant");

    // Round-robin from a fresh reset: 0,1,2,3,0 with one bubble per burst.
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    s = cyc;
    add_burst(0, 2, 0, 24'h000000, 1'b1, 0);
    add_burst(0, 2, 2, 24'h000002, 1'b1, 2);
    add_burst(1, 2, 1000, 24'h010000, 1'b1, 0);
    add_burst(2, 2, 2000, 24'h020000, 1'b1, 0);
    add_burst(3, 2, 3000, 24'h030000, 1'b1, 0);
    ord = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      ex(ord[k], s + 1 + 3 * k, (k == 4) ? 2 : 0);
      ex(ord[k], s + 2 + 3 * k, (k == 4) ? 3 : 1);
    end
    wait_idle("rr");
    chk_log("rr_order");

    // Four-beat burst: back-to-back acceptance and writes.
    @(posedge clk); #1;
    s = cyc;
    add_burst(1, 4, 100, 24'hFF0000, 1'b1, 0);
    for (int k = 0; k < 4; k++) ex(1, s + 1 + k, k);
    wait_idle("burst");
    chk_log("burst");

    // Burst cap: requester 2 is cut after 64 beats, requester 3 slips in.
    @(posedge clk); #1;
    s = cyc;
    add_burst(2, 70, 10000, 24'h200000, 1'b1, 1);
    add_burst(3, 2, 20000, 24'h300000, 1'b1, 1);
    for (int k = 1; k <= 64; k++) ex(2, s + k, k);
    ex(3, s + 66, 1);
    ex(3, s + 67, 2);
    for (int k = 65; k <= 70; k++) ex(2, s + 69 + (k - 65), k);
    wait_idle("maxburst");
    chk_log("maxburst");

    // Stall release: 16 idle cycles hand the port to requester 3.
    @(posedge clk); #1;
    s = cyc;
    add_burst(2, 2, 30000, 24'h400000, 1'b0, 1);
    add_idle(2, 16);
    add_burst(2, 1, 30002, 24'h400002, 1'b1, 3);
    repeat (3) @(posedge clk);
    #1 add_burst(3, 1, 31000, 24'h500000, 1'b1, 1);
    ex(2, s + 1, 1);
    ex(2, s + 2, 2);
    ex(3, s + 20, 1);
    ex(2, s + 22, 3);
    wait_idle("stall");
    chk_log("stall");

    // Out of bounds: last legal address writes, first illegal one sets the flag.
    @(posedge clk); #1;
    s = cyc;
    add_burst(1, 2, TOT - 1, 24'h600000, 1'b1, 1);
    ex(1, s + 1, 1);
    ex(1, s + 2, 2);
    wait_idle("oob");
    chk_log("oob");
    chk("oob_set", err_oob, 1);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    chk("oob_clear", err_oob, 0);
    @(posedge clk); #1;
    s = cyc;
    add_burst(1, 1, 400000, 24'h700000, 1'b1, 1);
    ex(1, s + 1, 1);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    chk("oob_set_wins", err_oob, 1);
    wait_idle("oob2");
    chk_log("oob_coincide");

    // Reset during beat 3 of a 6-beat burst.
    @(posedge clk); #1;
    s = cyc;
    add_burst(1, 6, 200, 24'h800000, 1'b1, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("inflight_we", fb_we, 1);
    chk("inflight_addr", fb_addr, 202);
    rst = 1'b0;
    #1;
    chk("midrst_we", fb_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", req_ready, 0);
    chk("midrst_err", err_oob, 0);
    exp_q.delete();
    add_burst(2, 1, 300, 24'h900000, 1'b1, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    r = cyc;
    ex(1, s + 1, 1);
    ex(1, s + 2, 2);
    ex(1, s + 3, 3);
    ex(1, r + 1, 4);
    ex(1, r + 2, 5);
    ex(1, r + 3, 6);
    ex(2, r + 5, 1);
    wait_idle("midrst");
    chk_log("midrst");

    chk("writes_drained", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
